// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle for uart_rx_param: line/enable in, word and status pulses out.
// The master modport is the side that drives the serial line and consumes the results.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 done;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output enable, rx,
        input  data_out, done, frame_err, parity_err, busy
    );

    modport slave (
        input  enable, rx,
        output data_out, done, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection, framing check and break hold-off.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (sense set by PARITY_ODD).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input logic      clk,
    input logic      rst,
    uart_rx_param_if.slave bus
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_idx_q;
    logic                 stop_bad_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q, ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_pulse_q;
`endif

    logic rx_fall;
    assign rx_fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is reset along with everything else; it is a handful of
            // flops, not a memory array, so a reset costs nothing and keeps data_out deterministic.
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            perr_pulse_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_pulse_q <= 1'b0;
`endif
            if (!bus.enable) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (rx_fall) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                    S_START: if (cnt_q == HALF_M1) begin
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_q     <= 1'b0;
`endif
                        // A line already back high at mid-start was a glitch.
                        state_q    <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    S_DATA: if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        perr_q  <= rx_s_q != ((^shift_q) ^ (PARITY_ODD != 0));
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                    S_STOP: if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (stop_idx_q == STOP_LAST) begin
                            if (stop_bad_q || !rx_s_q) begin
                                ferr_q  <= 1'b1;
                                state_q <= S_BREAK;
`ifdef UART_RX_PARITY_EN
                            end else if (perr_q) begin
                                perr_pulse_q <= 1'b1;
                                state_q      <= S_IDLE;
`endif
                            end else begin
                                data_q  <= shift_q;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            stop_bad_q <= stop_bad_q | ~rx_s_q;
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Hold off until the line idles so a held-low break cannot retrigger.
                    S_BREAK: if (rx_s_q) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_pulse_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (32 clocks/bit, 8 data bits, 1 stop bit).
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CPB = 32;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LATENCY = 2 + CPB / 2 + (8 + PBITS + 1) * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #1 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus ();

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_done_cyc = 0;
    int n_done = 0, n_ferr = 0, n_perr = 0;
    int d0, f0, p0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                n_done        = n_done + 1;
                last_done_cyc = cyc;
            end
            if (bus.frame_err)  n_ferr = n_ferr + 1;
            if (bus.parity_err) n_perr = n_perr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        d0 = n_done;
        f0 = n_ferr;
        p0 = n_perr;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus data bits 0..3 of an all-ones word, leaving us at the start of bit 4.
    task automatic partial_ff();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
    endtask

    initial begin
        bus.rx     = 1'b1;
        bus.enable = 1'b1;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_data_out",   32'(bus.data_out),   32'h0);
        check("rst_done",       32'(bus.done),       32'h0);
        check("rst_frame_err",  32'(bus.frame_err),  32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        check("rst_busy",       32'(bus.busy),       32'h0);
        idle(8);

        // Good frame 0x17 (even parity bit 0)
        snap();
        send_frame(8'h17, 1'b0, 1'b1);
        idle(8);
        check("f17_done_count", 32'(n_done - d0), 32'd1);
        check("f17_no_ferr",    32'(n_ferr - f0), 32'd0);
        check("f17_data",       32'(bus.data_out), 32'h17);
        check("f17_latency",    32'(last_done_cyc - fall_cyc), 32'(LATENCY));

        // False start: 10-cycle low glitch
        snap();
        bus.rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_mid", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch_busy_end", 32'(bus.busy), 32'd0);
        check("glitch_pulses",   32'((n_done - d0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
        check("glitch_data",     32'(bus.data_out), 32'h17);
        idle(8);

        // Framing error followed by a held-low break
        snap();
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("brk_busy_held", 32'(bus.busy), 32'd1);
        check("brk_ferr",      32'(n_ferr - f0), 32'd1);
        check("brk_no_done",   32'(n_done - d0), 32'd0);
        check("brk_data",      32'(bus.data_out), 32'h17);
        idle(10);
        check("brk_busy_rel",  32'(bus.busy), 32'd0);
        snap();
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(8);
        check("f3c_done_count", 32'(n_done - d0), 32'd1);
        check("f3c_data",       32'(bus.data_out), 32'h3C);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h01, 1'b1, 1'b1);
        idle(8);
        check("par_ok_done", 32'(n_done - d0), 32'd1);
        check("par_ok_data", 32'(bus.data_out), 32'h01);
        snap();
        send_frame(8'h01, 1'b0, 1'b1);
        idle(8);
        check("par_bad_perr",    32'(n_perr - p0), 32'd1);
        check("par_bad_no_done", 32'(n_done - d0), 32'd0);
        check("par_bad_data",    32'(bus.data_out), 32'h01);
`else
        check("par_tied_low", 32'(n_perr), 32'd0);
`endif

        // Enable dropped at bit 4 of 0xFF
        snap();
        partial_ff();
        bus.rx     = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("en_abort_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        repeat (CPB * (4 + PBITS + 1)) @(negedge clk);
        idle(8);
        check("en_abort_pulses", 32'((n_done - d0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
        snap();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(8);
        check("f55a_done", 32'(n_done - d0), 32'd1);
        check("f55a_data", 32'(bus.data_out), 32'h55);

        // Reset pulsed at bit 4 of 0xFF
        snap();
        partial_ff();
        bus.rx = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_busy", 32'(bus.busy), 32'd0);
        check("rst_abort_data", 32'(bus.data_out), 32'h0);
        repeat (CPB * (4 + PBITS + 1)) @(negedge clk);
        idle(8);
        check("rst_abort_pulses", 32'((n_done - d0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
        snap();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(8);
        check("f55b_done", 32'(n_done - d0), 32'd1);
        check("f55b_data", 32'(bus.data_out), 32'h55);
        check("f55b_latency", 32'(last_done_cyc - fall_cyc), 32'(LATENCY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
